sel_mux_pipe: RTL and testbench
===============================

# sel_mux_pipe

Parametrised N-input word selector with a registered, flow-controlled output. It generalises the datapath's fixed 5-way combinational selectors to N channels of WIDTH bits. The selected word passes through a 2-entry skid buffer with valid/ready handshakes on both sides, and out-of-range selects are flagged. It sits between pipeline stages where a select result must be held across downstream stalls, such as writeback source selection or the bus-response path.

## Interface
- WIDTH, 32, data width per channel
- N, 5, number of input channels, N >= 2
- SELW, derived as max(1, clog2(N)), width of the select field (not overridable)
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- in_data  in  N*WIDTH  flattened channels; channel i is in_data[i*WIDTH +: WIDTH]
- sel  in  SELW  channel index, sampled with in_data
- in_valid  in  1  upstream word/sel valid
- in_ready  out  1  block can accept this cycle
- out_data  out  WIDTH  selected word at buffer head
- out_sel  out  SELW  effective channel index used for out_data (0 if the select was out of range)
- out_valid  out  1  buffer non-empty
- out_ready  in  1  downstream accepts head
- oob  out  1  sticky flag: an accepted select was >= N
- clear_oob  in  1  clears oob

## Operation
- Push: in_valid && in_ready.
  - The selection is resolved at push time. If sel < N, the entry takes channel sel. Otherwise it takes channel 0 and effective sel 0, the legacy default.
  - The entry is written into a 2-entry FIFO (count 0..2, wr/rd pointers wrap mod 2).
- Pop: out_valid && out_ready. The head advances.
- Push and pop in the same cycle: the count is unchanged and data order is preserved.
- in_ready = resetn && (count != 2). It is driven only by registered state, so there is no combinational path from out_ready to in_ready.
- out_valid = (count != 0). out_data and out_sel come from the head entry register; there is no combinational path from in_data to out_data.
- oob:
  - Set on any push with sel >= N.
  - Cleared by clear_oob.
  - If set and clear happen in the same cycle, set wins.
- When N is a power of two, sel >= N is impossible and oob stays 0.
- Downstream stall: entries hold unchanged while out_ready is low. out_data must not change while out_valid && !out_ready.
- Inputs are ignored when in_valid is low, including X on in_data and sel.

## Timing
- Reset (resetn low at a clk edge):
  - count = 0 and pointers = 0.
  - out_valid = 0, out_data = 0, out_sel = 0, oob = 0.
  - in_ready = 0 while resetn is low, then 1 in the first cycle after release.
- Reset asserted mid-operation: all buffered entries are discarded with no pop handshake, and oob clears.
- Latency: a word pushed at edge k is visible at out_data with out_valid = 1 after edge k, i.e. 1 cycle.
- Throughput: 1 word/cycle while out_ready is held high; count stays at <= 1.
- Backpressure: with out_ready low, two pushes fill the buffer and in_ready deasserts in the cycle after the second push.
- Full drain: the first pop from count 2 reasserts in_ready in the next cycle. No push is accepted in the cycle of that pop.

## Test plan
- Reset/idle: hold resetn = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, out_data = 0, oob = 0. After release, in_ready = 1 and nothing is pushed during reset.
- Basic select (N = 5, WIDTH = 32), out_ready = 1, channel i = 0x100+i:
  - Push sel = 0..4 back-to-back.
  - Required: out_data = 0x100..0x104 on consecutive cycles, each 1 cycle after its push, and out_sel = 0..4.
- Out-of-range select: push sel = 6 -> out_data = channel 0 (0x100), out_sel = 0, oob = 1 from the next cycle. Pulse clear_oob -> oob = 0. Assert clear_oob together with another sel = 7 push -> oob stays 1.
- Backpressure: out_ready = 0, push A then B, offer C -> in_ready = 0 and C is not accepted. out_data holds A stable across 10 cycles. Raise out_ready -> A, B, C emerge in order with no loss or duplication.
- Simultaneous push/pop at count 1: streaming random sel with out_ready = 1 -> count never exceeds 1 and order matches a scoreboard over 1000 words.
- Reset mid-stream: with count = 2, assert resetn = 0 for 1 cycle -> out_valid = 0 and oob = 0 next cycle. Subsequent pushes deliver only new data.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// sel_mux_pipe: N-way word selector feeding a 2-entry skid buffer.
// The select is resolved when a word is pushed. Out-of-range selects fall back
// to channel 0 and raise a sticky oob flag. Both outputs and in_ready depend
// only on registered state (plus resetn), so stalls never ripple upstream
// combinationally.
module sel_mux_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 5,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 oob,
  input  logic                 clear_oob
);

  localparam logic [SELW:0] N_L = (SELW+1)'(N);

  logic [WIDTH-1:0] data_q [2];
  logic [SELW-1:0]  sel_q  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             oob_q, oob_d;

  logic             push, pop;
  logic             in_range;
  logic [SELW-1:0]  eff_sel;
  logic [WIDTH-1:0] pick;

  assign in_ready  = resetn && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_sel   = sel_q[rd_ptr_q];
  assign oob       = oob_q;

  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign in_range = ({1'b0, sel} < N_L);
  assign eff_sel  = in_range ? sel : '0;

  // Resolve the selected channel word for the current push.
  always_comb begin
    // NOTE: default first so every path assigns pick; otherwise a latch is inferred.
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (eff_sel == SELW'(i)) pick = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state for pointers, occupancy and the sticky out-of-range flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    oob_d    = oob_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (clear_oob)          oob_d = 1'b0;
    if (push && !in_range)  oob_d = 1'b1;  // set wins over clear
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!resetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      oob_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      oob_q    <= oob_d;
    end
  end

  // Entry storage; written only on push, held through downstream stalls.
  always_ff @(posedge clk) begin
    // NOTE: entries are reset because out_data/out_sel must read 0 after reset;
    // a plain storage array would normally be left unreset.
    if (!resetn) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      sel_q[0]  <= '0;
      sel_q[1]  <= '0;
    end else if (push) begin
      data_q[wr_ptr_q] <= pick;
      sel_q[wr_ptr_q]  <= eff_sel;
    end
  end

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe (N=5, WIDTH=32) with immediate assertions.
module tb_sel_mux_pipe;
  localparam int WIDTH = 32;
  localparam int N     = 5;
  localparam int SELW  = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N*WIDTH-1:0] in_data;
  logic [SELW-1:0]   sel;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [SELW-1:0]   out_sel;
  logic              out_valid;
  logic              out_ready;
  logic              oob;
  logic              clear_oob;

  logic [WIDTH-1:0]  ch [N];
  int                total = 0;
  int                bad   = 0;
  logic [WIDTH-1:0]  exp_q [$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = ch[i];
  end

  sel_mux_pipe #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oob       (oob),
    .clear_oob (clear_oob)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_channels();
    for (int i = 0; i < N; i++) ch[i] = 32'h100 + 32'(i);
  endtask

  initial begin
    logic [WIDTH-1:0] e;
    logic [SELW-1:0]  s;

    default_channels();
    resetn = 1'b0; in_valid = 1'b1; sel = '0; out_ready = 1'b1; clear_oob = 1'b0;

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
    end
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_oob",       32'(oob),       32'd0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("rel_no_push", 32'(out_valid), 32'd0);

    // Basic back-to-back select, one-cycle latency.
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      sel = SELW'(i);
      tick();
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_data",  out_data,       32'h100 + 32'(i));
      check("basic_sel",   32'(out_sel),   32'(i));
      check("basic_oob",   32'(oob),       32'd0);
    end
    in_valid = 1'b0;
    tick();
    check("basic_drained", 32'(out_valid), 32'd0);

    // Out-of-range select falls back to channel 0 and sets oob.
    in_valid = 1'b1; sel = 3'd6;
    tick();
    in_valid = 1'b0;
    check("oob6_data", out_data,     32'h100);
    check("oob6_sel",  32'(out_sel), 32'd0);
    check("oob6_flag", 32'(oob),     32'd1);
    clear_oob = 1'b1;
    tick();
    clear_oob = 1'b0;
    check("oob_cleared", 32'(oob), 32'd0);
    in_valid = 1'b1; sel = 3'd7; clear_oob = 1'b1;
    tick();
    in_valid = 1'b0; clear_oob = 1'b0;
    check("oob_set_wins", 32'(oob),     32'd1);
    check("oob7_sel",     32'(out_sel), 32'd0);
    check("oob7_data",    out_data,     32'h100);
    tick();
    clear_oob = 1'b1;
    tick();
    clear_oob = 1'b0;
    check("oob_cleared2", 32'(oob), 32'd0);

    // Backpressure: fill with A, B; C is offered but refused.
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'd1;
    tick();
    check("bp_one_ready", 32'(in_ready), 32'd1);
    sel = 3'd2;
    tick();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    sel = 3'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_data",  out_data,       32'h101);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_pop_b",    out_data,      32'h102);
    check("bp_reopen",   32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_pop_c",    out_data,      32'h103);
    check("bp_c_valid",  32'(out_valid), 32'd1);
    tick();
    check("bp_empty",    32'(out_valid), 32'd0);

    // Streaming with random select and data against a scoreboard.
    in_valid = 1'b1;
    for (int w = 0; w < 1000; w++) begin
      for (int i = 0; i < N; i++) ch[i] = $urandom();
      s   = SELW'($urandom_range(0, 7));
      sel = s;
      e   = (s < 3'(N)) ? ch[s] : ch[0];
      if (in_ready) exp_q.push_back(e);
      else check("stream_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() != 0) check("stream_data", out_data, exp_q.pop_front());
    end
    in_valid = 1'b0;
    tick();
    check("stream_empty", 32'(out_valid), 32'd0);
    clear_oob = 1'b1;
    tick();
    clear_oob = 1'b0;

    // Reset mid-stream with the buffer full.
    default_channels();
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 3'd5;
    tick();
    sel = 3'd2;
    tick();
    in_valid = 1'b0;
    check("mid_full",   32'(in_ready), 32'd0);
    check("mid_oob",    32'(oob),      32'd1);
    resetn = 1'b0;
    tick();
    check("mid_valid",    32'(out_valid), 32'd0);
    check("mid_oob_clr",  32'(oob),       32'd0);
    check("mid_in_ready", 32'(in_ready),  32'd0);
    check("mid_data",     out_data,       32'd0);
    resetn = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    check("mid_new_data", out_data,     32'h104);
    check("mid_new_sel",  32'(out_sel), 32'd4);
    tick();
    check("mid_no_stale", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
